// File: rtl/lsu_bus_ctrl_if.sv
// Bus-side handshake bundle for the load/store unit: a request/grant phase
// followed by an ack that carries the read data.
`default_nettype none

interface lsu_bus_ctrl_if;
  logic        bus_req;
  logic        bus_gnt;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_ack, bus_rdata
  );
endinterface

`default_nettype wire

// File: rtl/lsu_bus_ctrl.sv
// Load/store unit bus controller: IDLE/REQ/WAIT/DONE sequencer with lane
// steering, load extension and a WAIT timeout. Define LSU_MISALIGN_TRAP_EN
// to fault misaligned accesses instead of aligning them down.
`default_nettype none

module lsu_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [2:0]           funct3,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic                 stall,
  output logic                 err,
  lsu_bus_ctrl_if.master       bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  // Everything the load path needs once the datapath inputs have moved on.
  typedef struct packed {
    logic [2:0] funct3;
    logic [1:0] off;
  } acc_t;

  state_t        state;
  acc_t          acc;
  logic [CW-1:0] cnt;

  logic        access;
  logic        f3_ok;
  logic        trap;
  logic [1:0]  off_al;
  logic [3:0]  be;
  logic [31:0] wrep;
  logic [31:0] lsh;
  logic [31:0] ld;

  assign access = mem_read | mem_write;

  // funct3[1:0] is the size code: 00 byte, 01 half, 10 word.
  always_comb begin
    f3_ok  = 1'b0;
    off_al = 2'b00;
    be     = 4'b1111;
    wrep   = wdata;
    if (mem_write)
      f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    else
      f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
              (funct3 == 3'b100) || (funct3 == 3'b101);
    case (funct3[1:0])
      2'b00: begin
        off_al = addr[1:0];
        wrep   = {4{wdata[7:0]}};
        if (mem_write) be = 4'b0001 << off_al;
      end
      2'b01: begin
        off_al = {addr[1], 1'b0};
        wrep   = {2{wdata[15:0]}};
        if (mem_write) be = 4'b0011 << off_al;
      end
      default: begin
        off_al = 2'b00;
        wrep   = wdata;
        be     = 4'b1111;
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = ((funct3[1:0] == 2'b01) && addr[0]) ||
                ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  // Lane select uses the already size-aligned offset latched at request time.
  assign lsh = bus.bus_rdata >> {acc.off, 3'b000};

  always_comb begin
    ld = bus.bus_rdata;
    case (acc.funct3)
      3'b000:  ld = {{24{lsh[7]}}, lsh[7:0]};
      3'b001:  ld = {{16{lsh[15]}}, lsh[15:0]};
      3'b100:  ld = {24'd0, lsh[7:0]};
      3'b101:  ld = {16'd0, lsh[15:0]};
      default: ld = bus.bus_rdata;
    endcase
  end

  assign stall = (state == REQ) || (state == WAIT) || ((state == IDLE) && access);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      rdata         <= '0;
      err           <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= '0;
      bus.bus_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            if (!f3_ok || trap) begin
              state <= DONE;
              err   <= 1'b1;
              rdata <= '0;
            end else begin
              state         <= REQ;
              bus.bus_req   <= 1'b1;
              bus.bus_we    <= mem_write;
              bus.bus_addr  <= {addr[31:2], 2'b00};
              bus.bus_be    <= be;
              bus.bus_wdata <= wrep;
              acc           <= '{funct3: funct3, off: off_al};
            end
          end
        end
        REQ: begin
          if (bus.bus_gnt) begin
            state       <= WAIT;
            bus.bus_req <= 1'b0;
            cnt         <= '0;
          end
        end
        WAIT: begin
          if (bus.bus_ack) begin
            state <= DONE;
            rdata <= ld;
          end else begin
            // Counter stops at TIMEOUT_CYCLES because the state leaves WAIT.
            cnt <= cnt + 1'b1;
            if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
              state <= DONE;
              err   <= 1'b1;
              rdata <= '0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/lsu_bus_ctrl.md
LSU_BUS_CTRL -- requirements
Module: lsu_bus_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of WAIT cycles before the block aborts.
REQ-002 SHALL have one clock and a reset: the reset is asynchronous and active-high. Ports are named clk and reset, as the codebase does.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1: clock; all state updates on the rising edge.
- reset, in, 1: asynchronous active-high reset.
- mem_read, in, 1: the current instruction is a load.
- mem_write, in, 1: the current instruction is a store.
- funct3, in, 3: access size and sign.
- addr, in, 32: effective address from the datapath ALU result.
- wdata, in, 32: store data from the datapath second register operand.
- rdata, out, 32: load result into the datapath memory-data input.
- stall, out, 1: freezes PC and register write while an access is in progress.
- err, out, 1: access fault, a one-cycle pulse in DONE.
- bus_req, out, 1: bus request valid.
- bus_gnt, in, 1: bus accepts the request.
- bus_we, out, 1: write request.
- bus_addr, out, 32: word-aligned bus address.
- bus_be, out, 4: byte enables.
- bus_wdata, out, 32: lane-replicated store data.
- bus_ack, in, 1: completion; read data is valid with it.
- bus_rdata, in, 32: read data.

Function
REQ-004 SHALL implement the FSM states IDLE, REQ, WAIT and DONE.
REQ-005 IDLE: if mem_read or mem_write is 1, go to REQ next cycle. stall SHALL be 1 combinationally in this cycle.
REQ-006 REQ: bus_req=1 with addr, we, be and wdata stable. If bus_gnt=1, go to WAIT. Otherwise hold REQ with all outputs unchanged.
REQ-007 WAIT:
- On bus_ack, go to DONE.
- Each cycle without ack increments the timeout counter.
- When the counter equals TIMEOUT_CYCLES, go to DONE with err=1 and rdata=0.
REQ-008 DONE: stall=0 for exactly one cycle and rdata is valid. The next state is always IDLE; a new request is never started from DONE.
REQ-009 stall SHALL be 1 in REQ and WAIT, and 1 in IDLE whenever mem_read or mem_write is 1. stall SHALL be 0 otherwise.
REQ-010 If mem_read and mem_write are both 1, the access SHALL be treated as a store.
REQ-011 bus_addr SHALL be {addr[31:2],2'b00}.
REQ-012 Store byte enables:
- SB (funct3=000): bus_be=0001<<addr[1:0], bus_wdata={4{wdata[7:0]}}.
- SH (funct3=001): bus_be=0011<<addr[1:0], bus_wdata={2{wdata[15:0]}}.
- SW (funct3=010): bus_be=1111.
- Loads drive bus_be=1111.
REQ-013 The load lane SHALL be selected by addr[1:0].
- LB (000) and LH (001) sign-extend.
- LBU (100) and LHU (101) zero-extend.
- LW (010) passes the word through.
REQ-014 Any other funct3 value SHALL produce err=1 in DONE with no bus transaction; the path is IDLE->DONE directly.
REQ-015 bus_rdata SHALL be captured into a register on bus_ack. rdata is driven from that register and holds its value outside DONE.
REQ-016 A bus_ack received in IDLE, REQ or DONE SHALL be ignored.
REQ-017 The timeout counter SHALL clear on entry to WAIT and SHALL never wrap.

Reset
REQ-018 Reset SHALL asynchronously force:
- state=IDLE
- bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0
- rdata=0, err=0
- timeout counter=0
REQ-019 Reset during REQ or WAIT SHALL abandon the access. Any later ack for it SHALL be ignored per REQ-016.

Configuration
REQ-020 With macro LSU_MISALIGN_TRAP_EN defined, a misaligned access SHALL go IDLE->DONE with err=1 and issue no bus transaction. Misaligned means:
- halfword with addr[0]=1, or
- word with addr[1:0]!=00.
REQ-021 Without LSU_MISALIGN_TRAP_EN, misaligned accesses SHALL proceed:
- bus_be and the lane are computed as if addr were aligned down to the access size.
- err is never raised for alignment.

Verification
REQ-022 LW with addr=0x100, gnt after 2 cycles, ack with rdata=0xDEADBEEF -> bus_addr=0x100, be=1111, rdata=0xDEADBEEF in DONE, stall low exactly 1 cycle.
REQ-023 LB and LBU at addr=0x103, bus_rdata=0x80112233 -> rdata=0xFFFFFF80 and 0x00000080 respectively.
REQ-024 SH at addr=0x202, wdata=0x0000ABCD -> bus_we=1, bus_addr=0x200, be=1100, bus_wdata=0xABCDABCD.
REQ-025 LW with no ack and TIMEOUT_CYCLES=4 -> DONE after 4 WAIT cycles, err=1, rdata=0.
REQ-026 LW at addr=0x101 -> with LSU_MISALIGN_TRAP_EN: err=1 and bus_req never asserted. Without it: bus_addr=0x100, be=1111, err=0.
REQ-027 reset asserted in WAIT, then ack pulsed in IDLE -> all outputs at reset values, the ack is ignored, and the next request proceeds normally.
